dir_request_controller: RTL and testbench

//  Sequences the MSI L2 directory for the two L1 caches, P0,0 (index 0) and P0,1 (index 1).
//  - Arbitrates their requests round-robin.
//  - Looks up, allocates and updates the directory table it owns (address, state, data, sharers).
//  - Issues invalidations/downgrades to sharers and fetch/writeback transactions to memory.
//  - Returns the response to the requester.

---
 rtl/dir_request_controller.sv | 254 +++++++++++++++++++++++++
 tb/tb_dir_request_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dir_request_controller.sv
// dir_request_controller
//   Directory sequencer for an MSI L2 shared by two L1 caches (P0,0 and P0,1).
//   Grants one request at a time using round-robin arbitration.
//   Looks up or allocates a directory entry (address, state, data, sharers).
//   Sends invalidations/downgrades to sharers, then writebacks/fetches to memory.
//   Updates the entry and pulses the response back to the requester.
// Ports
//   Clock, Reset                  clock, asynchronous active-high reset
//   ReqValid/ReqWrite/ReqAddrN/ReqDataN -> ReqReady   request in, one-cycle grant out
//   RespValid/RespData            one-cycle completion to the requester
//   InvValid/InvAddr/InvDown <- InvAck/InvData        invalidate/downgrade handshake
//   MemReq/MemWrite/MemAddr/MemWData <- MemRData/MemDone   memory handshake
// Entry state encoding: 00 empty, 01 I, 10 S, 11 M; sharers bit i = processor i.
module dir_request_controller #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 4,
   parameter int ENTRIES = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [1:0]        ReqValid,
   input  logic [1:0]        ReqWrite,
   input  logic [ADDR_W-1:0] ReqAddr0,
   input  logic [ADDR_W-1:0] ReqAddr1,
   input  logic [DATA_W-1:0] ReqData0,
   input  logic [DATA_W-1:0] ReqData1,
   output logic [1:0]        ReqReady,
   output logic [1:0]        RespValid,
   output logic [DATA_W-1:0] RespData,
   output logic [1:0]        InvValid,
   output logic [ADDR_W-1:0] InvAddr,
   output logic              InvDown,
   input  logic [1:0]        InvAck,
   input  logic [DATA_W-1:0] InvData,
   output logic              MemReq,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   input  logic [DATA_W-1:0] MemRData,
   input  logic              MemDone
);
   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_S     = 2'b10;
   localparam logic [1:0] ST_M     = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_INVAL, S_WBACK, S_MEMRD, S_UPDATE, S_RESP
   } fsm_t;

   fsm_t              fsm_q, fsm_d;
   logic              rr_q, rr_d;              // processor granted last on a contested cycle
   logic [IDX_W-1:0]  victim_q, victim_d;
   logic              req_id_q, req_id_d;
   logic              req_write_q, req_write_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [1:0]        inv_mask_q, inv_mask_d;  // processors still to be invalidated
   logic              inv_down_q, inv_down_d;
   logic              capture_q, capture_d;    // owner was M: take InvData on its ack
   logic              wb_q, wb_d;
   logic              fetch_q, fetch_d;
   logic [ADDR_W-1:0] tgt_addr_q, tgt_addr_d;  // address for INVAL and WBACK
   logic [DATA_W-1:0] data_q, data_d;          // working copy of the block
   logic [1:0]        new_state_q, new_state_d;
   logic [1:0]        new_sharers_q, new_sharers_d;

   logic [1:0]        ent_state_q   [ENTRIES];
   logic [1:0]        ent_state_d   [ENTRIES];
   logic [1:0]        ent_sharers_q [ENTRIES];
   logic [1:0]        ent_sharers_d [ENTRIES];
   logic [ADDR_W-1:0] ent_addr_q    [ENTRIES];
   logic [ADDR_W-1:0] ent_addr_d    [ENTRIES];
   logic [DATA_W-1:0] ent_data_q    [ENTRIES];
   logic [DATA_W-1:0] ent_data_d    [ENTRIES];

   logic [ENTRIES-1:0] match_vec, empty_vec;
   logic [IDX_W-1:0]   hit_idx, empty_idx;
   logic [1:0]         req_bit, tgt_bit, cur_state, cur_sharers;
   logic               gnt_id;

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
         assign match_vec[gi] = (ent_state_q[gi] != ST_EMPTY) && (ent_addr_q[gi] == req_addr_q);
         assign empty_vec[gi] = (ent_state_q[gi] == ST_EMPTY);
      end
   endgenerate

   assign req_bit = req_id_q ? 2'b10 : 2'b01;

   // Lowest-index matching entry and lowest-index empty entry.
   always_comb begin
      hit_idx   = '0;
      empty_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (match_vec[i]) hit_idx = IDX_W'(i);
         if (empty_vec[i]) empty_idx = IDX_W'(i);
      end
   end

   always_comb begin
      fsm_d = fsm_q;  rr_d = rr_q;  victim_d = victim_q;
      req_id_d = req_id_q;  req_write_d = req_write_q;
      req_addr_d = req_addr_q;  req_wdata_d = req_wdata_q;
      idx_d = idx_q;  inv_mask_d = inv_mask_q;  inv_down_d = inv_down_q;
      capture_d = capture_q;  wb_d = wb_q;  fetch_d = fetch_q;
      tgt_addr_d = tgt_addr_q;  data_d = data_q;
      new_state_d = new_state_q;  new_sharers_d = new_sharers_q;
      ent_state_d = ent_state_q;  ent_sharers_d = ent_sharers_q;
      ent_addr_d = ent_addr_q;  ent_data_d = ent_data_q;
      gnt_id = 1'b0;  tgt_bit = 2'b00;
      cur_state = ent_state_q[hit_idx];
      cur_sharers = ent_sharers_q[hit_idx];
      ReqReady = 2'b00;  RespValid = 2'b00;  RespData = '0;
      InvValid = 2'b00;  InvAddr = '0;  InvDown = 1'b0;
      MemReq = 1'b0;  MemWrite = 1'b0;  MemAddr = '0;  MemWData = '0;

      case (fsm_q)
         S_IDLE: begin
            // Grant is suppressed during reset so every output reads 0 then.
            if (ReqValid != 2'b00 && !Reset) begin
               if (ReqValid == 2'b11) begin
                  gnt_id = ~rr_q;
                  rr_d   = ~rr_q;
               end else begin
                  gnt_id = ReqValid[1];
               end
               ReqReady    = gnt_id ? 2'b10 : 2'b01;
               req_id_d    = gnt_id;
               req_write_d = ReqWrite[gnt_id];
               req_addr_d  = gnt_id ? ReqAddr1 : ReqAddr0;
               req_wdata_d = gnt_id ? ReqData1 : ReqData0;
               fsm_d       = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            inv_mask_d = 2'b00;  inv_down_d = 1'b0;  capture_d = 1'b0;
            wb_d = 1'b0;  fetch_d = 1'b0;  tgt_addr_d = req_addr_q;
            if (|match_vec) begin
               idx_d  = hit_idx;
               data_d = ent_data_q[hit_idx];
               if (req_write_q) begin
                  inv_mask_d    = cur_sharers & ~req_bit;
                  new_state_d   = ST_M;
                  new_sharers_d = req_bit;
               end else if (cur_state == ST_M && cur_sharers != req_bit) begin
                  // Remote owner: downgrade it, keep its data, write it back.
                  inv_mask_d    = cur_sharers & ~req_bit;
                  inv_down_d    = 1'b1;
                  capture_d     = 1'b1;
                  wb_d          = 1'b1;
                  new_state_d   = ST_S;
                  new_sharers_d = cur_sharers | req_bit;
               end else begin
                  new_state_d   = (cur_state == ST_M) ? ST_M : ST_S;
                  new_sharers_d = cur_sharers | req_bit;
               end
            end else begin
               if (|empty_vec) begin
                  idx_d = empty_idx;
               end else begin
                  // Evict the round-robin victim; its owner's data is authoritative.
                  idx_d      = victim_q;
                  victim_d   = victim_q + IDX_W'(1);
                  inv_mask_d = ent_sharers_q[victim_q];
                  capture_d  = (ent_state_q[victim_q] == ST_M);
                  wb_d       = (ent_state_q[victim_q] == ST_M);
                  tgt_addr_d = ent_addr_q[victim_q];
                  data_d     = ent_data_q[victim_q];
               end
               fetch_d       = ~req_write_q;
               new_state_d   = req_write_q ? ST_M : ST_S;
               new_sharers_d = req_bit;
            end
            if (inv_mask_d != 2'b00) fsm_d = S_INVAL;
            else if (wb_d)           fsm_d = S_WBACK;
            else if (fetch_d)        fsm_d = S_MEMRD;
            else                     fsm_d = S_UPDATE;
         end
         S_INVAL: begin
            // P0,0 is served before P0,1; acks on the other bit are ignored.
            tgt_bit  = inv_mask_q[0] ? 2'b01 : 2'b10;
            InvValid = tgt_bit;
            InvAddr  = tgt_addr_q;
            InvDown  = inv_down_q;
            if ((InvAck & tgt_bit) != 2'b00) begin
               inv_mask_d = inv_mask_q & ~tgt_bit;
               if (capture_q) data_d = InvData;
               if ((inv_mask_q & ~tgt_bit) == 2'b00) begin
                  if (wb_q)         fsm_d = S_WBACK;
                  else if (fetch_q) fsm_d = S_MEMRD;
                  else              fsm_d = S_UPDATE;
               end
            end
         end
         S_WBACK: begin
            MemReq   = 1'b1;
            MemWrite = 1'b1;
            MemAddr  = tgt_addr_q;
            MemWData = data_q;
            if (MemDone) fsm_d = fetch_q ? S_MEMRD : S_UPDATE;
         end
         S_MEMRD: begin
            MemReq  = 1'b1;
            MemAddr = req_addr_q;
            if (MemDone) begin
               data_d = MemRData;
               fsm_d  = S_UPDATE;
            end
         end
         S_UPDATE: begin
            data_d                = req_write_q ? req_wdata_q : data_q;
            ent_state_d[idx_q]    = new_state_q;
            ent_sharers_d[idx_q]  = new_sharers_q;
            ent_addr_d[idx_q]     = req_addr_q;
            ent_data_d[idx_q]     = req_write_q ? req_wdata_q : data_q;
            fsm_d                 = S_RESP;
         end
         S_RESP: begin
            RespValid = req_bit;
            RespData  = data_q;
            fsm_d     = S_IDLE;
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         fsm_q <= S_IDLE;  rr_q <= 1'b1;  victim_q <= '0;
         req_id_q <= 1'b0;  req_write_q <= 1'b0;  req_addr_q <= '0;  req_wdata_q <= '0;
         idx_q <= '0;  inv_mask_q <= 2'b00;  inv_down_q <= 1'b0;  capture_q <= 1'b0;
         wb_q <= 1'b0;  fetch_q <= 1'b0;  tgt_addr_q <= '0;  data_q <= '0;
         new_state_q <= ST_EMPTY;  new_sharers_q <= 2'b00;
         for (int i = 0; i < ENTRIES; i++) begin
            ent_state_q[i]   <= ST_EMPTY;
            ent_sharers_q[i] <= 2'b00;
            ent_addr_q[i]    <= '0;
            ent_data_q[i]    <= '0;
         end
      end else begin
         fsm_q <= fsm_d;  rr_q <= rr_d;  victim_q <= victim_d;
         req_id_q <= req_id_d;  req_write_q <= req_write_d;
         req_addr_q <= req_addr_d;  req_wdata_q <= req_wdata_d;
         idx_q <= idx_d;  inv_mask_q <= inv_mask_d;  inv_down_q <= inv_down_d;
         capture_q <= capture_d;  wb_q <= wb_d;  fetch_q <= fetch_d;
         tgt_addr_q <= tgt_addr_d;  data_q <= data_d;
         new_state_q <= new_state_d;  new_sharers_q <= new_sharers_d;
         ent_state_q <= ent_state_d;  ent_sharers_q <= ent_sharers_d;
         ent_addr_q <= ent_addr_d;  ent_data_q <= ent_data_d;
      end
   end
endmodule

// File: tb/tb_dir_request_controller.sv
// Directed bench for dir_request_controller with background L1/memory responders.
module tb_dir_request_controller;
   logic       Clock, Reset;
   logic [1:0] ReqValid, ReqWrite, ReqReady, RespValid, InvValid, InvAck;
   logic [3:0] ReqAddr0, ReqAddr1, ReqData0, ReqData1, RespData, InvAddr, InvData;
   logic [3:0] MemAddr, MemWData, MemRData;
   logic       InvDown, MemReq, MemWrite, MemDone;

   dir_request_controller dut (
      .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
      .ReqAddr0(ReqAddr0), .ReqAddr1(ReqAddr1), .ReqData0(ReqData0), .ReqData1(ReqData1),
      .ReqReady(ReqReady), .RespValid(RespValid), .RespData(RespData),
      .InvValid(InvValid), .InvAddr(InvAddr), .InvDown(InvDown), .InvAck(InvAck),
      .InvData(InvData), .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr),
      .MemWData(MemWData), .MemRData(MemRData), .MemDone(MemDone)
   );

   int n_total = 0, n_bad = 0, cyc = 0;
   bit mem_auto = 1, inv_auto = 1, inv_wrong = 0;
   int mem_lat = 0, inv_lat = 0;
   logic [3:0] inv_data_val = 4'h0;
   logic [1:0] inv_seen;
   logic       inv_down_seen;
   int         inv_cycles, wb_cnt, fetch_cnt;
   logic [3:0] wb_addr, wb_data, fetch_addr;

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   initial forever begin
      @(posedge Clock);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_obs();
      inv_seen = 2'b00; inv_down_seen = 1'b0; inv_cycles = 0;
      wb_cnt = 0; fetch_cnt = 0; wb_addr = 4'h0; wb_data = 4'h0; fetch_addr = 4'h0;
   endtask

   // Memory model: fetch returns addr ^ 0011; MemDone after mem_lat extra cycles.
   initial begin
      int mcnt;
      MemDone = 1'b0; MemRData = 4'h0; mcnt = 0;
      forever begin
         @(posedge Clock); #1;
         MemDone = 1'b0;
         if (mem_auto && MemReq) begin
            mcnt++;
            if (mcnt > mem_lat) begin
               MemDone = 1'b1; MemRData = MemAddr ^ 4'b0011; mcnt = 0;
            end
         end else mcnt = 0;
      end
   end

   // L1 model: acks the targeted processor after inv_lat extra cycles;
   // optionally pulses an ack on the non-target bit first.
   initial begin
      int icnt;
      InvAck = 2'b00; InvData = 4'h0; icnt = 0;
      forever begin
         @(posedge Clock); #1;
         InvAck = 2'b00;
         if (inv_auto && InvValid != 2'b00) begin
            icnt++;
            if (icnt > inv_lat) begin
               InvAck = InvValid; InvData = inv_data_val; icnt = 0;
            end else if (inv_wrong && icnt == 1) begin
               InvAck = ~InvValid;
            end
         end else icnt = 0;
      end
   end

   initial forever begin
      @(negedge Clock);
      if (InvValid != 2'b00) begin
         inv_seen |= InvValid; inv_down_seen = InvDown; inv_cycles++;
      end
      if (MemReq && MemDone) begin
         if (MemWrite) begin wb_cnt++; wb_addr = MemAddr; wb_data = MemWData; end
         else begin fetch_cnt++; fetch_addr = MemAddr; end
      end
   end

   task automatic set_fields(input int id, input logic w, input logic [3:0] a, input logic [3:0] d);
      if (id == 0) begin ReqAddr0 = a; ReqData0 = d; end
      else begin ReqAddr1 = a; ReqData1 = d; end
      ReqWrite[id] = w;
   endtask

   // One request from one processor; lat = cycles from the grant cycle to RespValid.
   task automatic do_req(input int id, input logic w, input logic [3:0] a, input logic [3:0] d,
                         output logic [1:0] gnt, output logic [1:0] rv,
                         output logic [3:0] rd, output int lat);
      int g;
      bit ok;
      set_fields(id, w, a, d);
      clear_obs();
      gnt = 2'b00; rv = 2'b00; rd = 4'h0; lat = -1; ok = 0;
      ReqValid[id] = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge Clock);
         if (ReqReady != 2'b00) begin ok = 1; gnt = ReqReady; break; end
      end
      if (!ok) begin
         chk("grant_timeout", 0, 1);
         ReqValid = 2'b00;
         return;
      end
      g = cyc;
      @(posedge Clock); #1;
      ReqValid[id] = 1'b0;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge Clock);
         if (RespValid != 2'b00) begin
            ok = 1; rv = RespValid; rd = RespData; lat = cyc - g; break;
         end
      end
      if (!ok) chk("resp_timeout", 0, 1);
      @(posedge Clock); #1;
   endtask

   // Both processors request continuously; checks grant order, no grant while busy,
   // response data and fetch count per transaction. ReqValid must already be 11.
   task automatic run_both(input string tag, input int n, input logic [5:0] eg,
                           input logic [11:0] ed, input logic [2:0] ef);
      bit ok;
      int early;
      for (int k = 0; k < n; k++) begin
         clear_obs();
         ok = 0;
         for (int j = 0; j < 50; j++) begin
            @(negedge Clock);
            if (ReqReady != 2'b00) begin ok = 1; break; end
         end
         if (!ok) begin chk({tag, "_grant_timeout"}, 0, 1); break; end
         chk({tag, "_grant"}, ReqReady, eg[k*2 +: 2]);
         if (k == n - 1) begin
            @(posedge Clock); #1;
            ReqValid = 2'b00;
         end
         ok = 0; early = 0;
         for (int j = 0; j < 200; j++) begin
            @(negedge Clock);
            if (ReqReady != 2'b00) early++;
            if (RespValid != 2'b00) begin
               ok = 1;
               chk({tag, "_resp"}, RespValid, eg[k*2 +: 2]);
               chk({tag, "_data"}, RespData, ed[k*4 +: 4]);
               chk({tag, "_fetch"}, fetch_cnt, ef[k]);
               break;
            end
         end
         if (!ok) chk({tag, "_resp_timeout"}, 0, 1);
         chk({tag, "_busy_grant"}, early, 0);
      end
      ReqValid = 2'b00;
      @(posedge Clock); #1;
   endtask

   initial begin
      logic [1:0] g, rv;
      logic [3:0] rd;
      int lat;
      bit ok;
      Reset = 1'b1; ReqValid = 2'b11; ReqWrite = 2'b00;
      ReqAddr0 = 4'h0; ReqAddr1 = 4'h0; ReqData0 = 4'h0; ReqData1 = 4'h0;
      clear_obs();
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      chk("rst_ready", ReqReady, 2'b00);
      chk("rst_resp", RespValid, 2'b00);
      chk("rst_inv", InvValid, 2'b00);
      chk("rst_mem", MemReq, 1'b0);
      ReqValid = 2'b00;
      @(posedge Clock); #1; Reset = 1'b0;
      @(posedge Clock); #1;

      // 1: read miss to 0001, fetched (1 wait cycle)
      mem_lat = 1;
      do_req(0, 1'b0, 4'b0001, 4'h0, g, rv, rd, lat);
      chk("t1_grant", g, 2'b01);
      chk("t1_resp", rv, 2'b01);
      chk("t1_data", rd, 4'b0010);
      chk("t1_fetch_cnt", fetch_cnt, 1);
      chk("t1_fetch_addr", fetch_addr, 4'b0001);
      chk("t1_wb_cnt", wb_cnt, 0);
      chk("t1_lat", lat, 5);
      mem_lat = 0;

      // 2: contested requests, P0 0001 (hit) / P1 0010 (miss) -> P0,P1,P0
      ReqAddr0 = 4'b0001; ReqAddr1 = 4'b0010; ReqWrite = 2'b00; ReqValid = 2'b11;
      run_both("t2", 3, 6'b01_10_01, {4'b0010, 4'b0001, 4'b0010}, 3'b010);

      // 3: P1 read hit on S entry
      do_req(1, 1'b0, 4'b0001, 4'h0, g, rv, rd, lat);
      chk("t3_resp", rv, 2'b10);
      chk("t3_data", rd, 4'b0010);
      chk("t3_inv", inv_seen, 2'b00);
      chk("t3_fetch", fetch_cnt, 0);
      chk("t3_lat", lat, 3);

      // 4: P0 write hit, P1 invalidated; stray ack on P0 bit ignored
      inv_lat = 2; inv_wrong = 1;
      do_req(0, 1'b1, 4'b0001, 4'b1001, g, rv, rd, lat);
      chk("t4_resp", rv, 2'b01);
      chk("t4_data", rd, 4'b1001);
      chk("t4_inv", inv_seen, 2'b10);
      chk("t4_down", inv_down_seen, 1'b0);
      chk("t4_inv_cycles", inv_cycles, 3);
      chk("t4_lat", lat, 6);
      inv_lat = 0; inv_wrong = 0;

      // 5: P1 read of line M in P0 -> downgrade and writeback
      inv_data_val = 4'b1001;
      do_req(1, 1'b0, 4'b0001, 4'h0, g, rv, rd, lat);
      chk("t5_resp", rv, 2'b10);
      chk("t5_data", rd, 4'b1001);
      chk("t5_inv", inv_seen, 2'b01);
      chk("t5_down", inv_down_seen, 1'b1);
      chk("t5_wb_cnt", wb_cnt, 1);
      chk("t5_wb_addr", wb_addr, 4'b0001);
      chk("t5_wb_data", wb_data, 4'b1001);
      chk("t5_lat", lat, 5);

      // 6: make entry 0 M, fill entries 2 and 3, then evict entry 0
      do_req(0, 1'b1, 4'b0001, 4'b0110, g, rv, rd, lat);
      chk("t6_wr_data", rd, 4'b0110);
      chk("t6_wr_inv", inv_seen, 2'b10);
      do_req(1, 1'b1, 4'b0011, 4'b0111, g, rv, rd, lat);
      chk("t6_wmiss_data", rd, 4'b0111);
      chk("t6_wmiss_fetch", fetch_cnt, 0);
      do_req(0, 1'b0, 4'b0100, 4'h0, g, rv, rd, lat);
      chk("t6_rmiss_data", rd, 4'b0111);
      inv_data_val = 4'b0110;
      do_req(1, 1'b0, 4'b0101, 4'h0, g, rv, rd, lat);
      chk("t6_evict_resp", rv, 2'b10);
      chk("t6_evict_inv", inv_seen, 2'b01);
      chk("t6_evict_down", inv_down_seen, 1'b0);
      chk("t6_evict_wb_addr", wb_addr, 4'b0001);
      chk("t6_evict_wb_data", wb_data, 4'b0110);
      chk("t6_evict_fetch", fetch_addr, 4'b0101);
      chk("t6_evict_data", rd, 4'b0110);
      chk("t6_evict_lat", lat, 6);

      // 6b: next miss evicts entry 1; Reset asserted while MEMRD is stalled
      mem_auto = 0;
      clear_obs();
      set_fields(1, 1'b0, 4'b0110, 4'h0);
      ReqValid[1] = 1'b1;
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge Clock);
         if (ReqReady != 2'b00) begin ok = 1; break; end
      end
      chk("t6r_grant", ok, 1'b1);
      @(posedge Clock); #1;
      ReqValid = 2'b00;
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge Clock);
         if (MemReq) begin ok = 1; break; end
      end
      chk("t6r_memreq", ok, 1'b1);
      chk("t6r_memwrite", MemWrite, 1'b0);
      chk("t6r_memaddr", MemAddr, 4'b0110);
      chk("t6r_victim_inv", inv_seen, 2'b10);
      #2 Reset = 1'b1;
      #1;
      chk("t6r_rst_memreq", MemReq, 1'b0);
      chk("t6r_rst_memaddr", MemAddr, 4'h0);
      chk("t6r_rst_inv", InvValid, 2'b00);
      chk("t6r_rst_resp", RespValid, 2'b00);
      chk("t6r_rst_ready", ReqReady, 2'b00);
      @(posedge Clock); @(posedge Clock); #1;
      Reset = 1'b0; mem_auto = 1;
      @(posedge Clock); #1;

      // After reset: P0 wins first and previously cached lines miss again
      ReqAddr0 = 4'b0001; ReqAddr1 = 4'b0101; ReqWrite = 2'b00; ReqValid = 2'b11;
      run_both("t6p", 2, 6'b00_10_01, {4'h0, 4'b0110, 4'b0010}, 3'b011);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d exp=0", cyc);
      $fatal(1, "timeout");
   end
endmodule
